vga_rect_fill_master: RTL and testbench
=======================================

Name: vga_rect_fill_master

Overview:
- Bus initiator that fills axis-aligned rectangles in the 160x120 1-bit frame buffer.
- Issues write transactions to the VGA peripheral registers: 0xB0 (Y), 0xB1 (X) and 0xB2 (pixel data, bit 0).
- Sits on the shared 8-bit data bus beside the CPU and requests bus ownership through a simple REQ/GNT pair.
- Offloads bulk clears and box draws from the processor.

Parameters:
- FB_WIDTH, 160, frame buffer columns (X range 0..FB_WIDTH-1)
- FB_HEIGHT, 120, frame buffer rows (Y range 0..FB_HEIGHT-1)
- BASE_ADDR, 8'hB0, Y register address; X is BASE_ADDR+1, data is BASE_ADDR+2

Ports:
- CLK  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command request
- CMD_READY  out  1  block can accept a command (high only in IDLE)
- CMD_X0  in  8  left column
- CMD_Y0  in  7  top row
- CMD_W  in  8  width in pixels
- CMD_H  in  7  height in pixels
- CMD_COLOUR  in  1  pixel value to write
- BUS_REQ  out  1  bus ownership request
- BUS_GNT  in  1  bus grant from arbiter
- BUS_ADDR  out  8  bus address
- BUS_DATA  out  8  bus write data
- BUS_WE  out  1  bus write strobe
- BUSY  out  1  command in progress
- DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state): FSM to IDLE, all counters cleared. Outputs: CMD_READY=1, BUS_REQ=0, BUS_WE=0, BUS_ADDR=0, BUS_DATA=0, BUSY=0, DONE=0. A fill in progress is abandoned; no further writes are issued.
- Command accept: on a rising edge with CMD_VALID && CMD_READY. X0, Y0, colour and clipped dimensions are latched at that edge.
- Clipping:
  - Weff = min(W, FB_WIDTH-X0); Heff = min(H, FB_HEIGHT-Y0).
  - If X0>=FB_WIDTH or Y0>=FB_HEIGHT, Weff=Heff=0.
  - Arithmetic is done at 9 bits to avoid wrap.
- States: IDLE, WR_Y, WR_X, WR_D, DONE.
  - IDLE -> DONE on accept when Weff==0 or Heff==0.
  - IDLE -> WR_Y on any other accept.
  - WR_Y -> WR_X -> WR_D.
  - WR_D -> WR_X while columns remain in the current row.
  - WR_D -> WR_Y at end of row when rows remain; Y increments and X resets to X0.
  - WR_D -> DONE after the last pixel.
  - DONE -> IDLE unconditionally.
- Write states:
  - BUS_REQ=1 in WR_Y, WR_X and WR_D.
  - BUS_WE=BUS_GNT (combinational).
  - A state advances only on an edge where BUS_GNT=1. Without grant the state is held and BUS_WE stays 0.
  - BUS_ADDR and BUS_DATA are 0 whenever BUS_WE=0, so the bus can be OR-combined.
- Write contents:
  - WR_Y: ADDR=BASE_ADDR, DATA={1'b0, Ycur}.
  - WR_X: ADDR=BASE_ADDR+1, DATA=Xcur.
  - WR_D: ADDR=BASE_ADDR+2, DATA={7'b0, colour}.
- Write order per row: one Y write, then an X/D write pair per pixel. The Y register is not rewritten within a row.
- Write count and latency with GNT held high:
  - Total writes = Heff*(1+2*Weff), one per cycle.
  - First write appears in the cycle after accept.
  - DONE is asserted for exactly one cycle, the cycle after the last write.
- BUSY=1 in all states except IDLE. BUSY stays 1 during the DONE cycle.
- CMD_READY=0 outside IDLE; commands presented while busy are not accepted.
- Grant loss between writes: the sequence resumes at the same write. No write is ever skipped or duplicated.

Decomposition:
- Shared package vga_pkg holds:
  - FB_WIDTH and FB_HEIGHT
  - register offsets (Y=0, X=1, DATA=2)
  - state enum/localparams for the fill FSM
- No sub-module: the clip logic and the X/Y counters are small and stay inline.

Test Plan:
- Single pixel: reset, GNT=1, cmd X0=5 Y0=3 W=1 H=1 colour=1. Required: writes (B0,03), (B1,05), (B2,01) on three consecutive cycles; DONE pulses the next cycle; READY returns high.
- 2x2 fill: X0=10 Y0=20 colour=0, GNT=1. Required: sequence B0=14, B1=0A, B2=00, B1=0B, B2=00, B0=15, B1=0A, B2=00, B1=0B, B2=00; 10 writes total; DONE at cycle 11.
- Clipping: X0=159 Y0=119 W=4 H=3 colour=1. Required: exactly one pixel written: B0=77, B1=9F, B2=01. Separately, X0=200: zero writes and DONE in the cycle after accept.
- Grant loss: 1x3 fill with GNT dropped for 4 cycles after the second write. Required: BUS_WE=0 and BUS_ADDR=BUS_DATA=0 during the gap, BUS_REQ stays 1, resume with the third write, total 7 writes with no duplicates.
- Busy rejection / zero size: CMD_VALID held during a fill keeps CMD_READY=0 with no effect on the sequence. W=0 gives DONE one cycle after accept with no BUS_WE.
- Reset mid-fill: assert RESET during WR_X of a 4x4 fill. Required: outputs take reset values immediately (async); no writes after release; a new 1x1 command then completes normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and FSM state type for the VGA rectangle fill master.
package vga_pkg;

  // Frame buffer geometry (1-bit pixels)
  localparam int unsigned FB_WIDTH  = 160;
  localparam int unsigned FB_HEIGHT = 120;

  // Default register base and per-register offsets from it
  localparam logic [7:0] BASE_ADDR    = 8'hB0;
  localparam logic [7:0] REG_Y_OFS    = 8'd0;
  localparam logic [7:0] REG_X_OFS    = 8'd1;
  localparam logic [7:0] REG_DATA_OFS = 8'd2;

  typedef enum logic [2:0] {
    StIdle,
    StWrY,
    StWrX,
    StWrD,
    StDone
  } fill_state_e;

endpackage

// File: rtl/vga_rect_fill_master_if.sv
// Command and bus signals of the rectangle fill master.
interface vga_rect_fill_master_if;

  logic       CMD_VALID;
  logic       CMD_READY;
  logic [7:0] CMD_X0;
  logic [6:0] CMD_Y0;
  logic [7:0] CMD_W;
  logic [6:0] CMD_H;
  logic       CMD_COLOUR;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       BUSY;
  logic       DONE;

  // Fill block side
  modport master (
    input  CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOUR, BUS_GNT,
    output CMD_READY, BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE
  );

  // Command source / arbiter / bus side
  modport slave (
    output CMD_VALID, CMD_X0, CMD_Y0, CMD_W, CMD_H, CMD_COLOUR, BUS_GNT,
    input  CMD_READY, BUS_REQ, BUS_ADDR, BUS_DATA, BUS_WE, BUSY, DONE
  );

endinterface

// File: rtl/vga_rect_fill_master.sv
// Bus initiator that fills a clipped rectangle of the 1-bit frame buffer by
// writing Y once per row, then an X/data pair per pixel.
module vga_rect_fill_master #(
  parameter int unsigned FB_WIDTH  = vga_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT = vga_pkg::FB_HEIGHT,
  parameter logic [7:0]  BASE_ADDR = vga_pkg::BASE_ADDR
) (
  input logic                    CLK,
  input logic                    RESET,
  vga_rect_fill_master_if.master bus
);

  import vga_pkg::*;

  localparam logic [8:0] FbW = 9'(FB_WIDTH);
  localparam logic [8:0] FbH = 9'(FB_HEIGHT);

  fill_state_e state_q;
  logic [7:0]  x0_q;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [8:0]  x_last_q;
  logic [8:0]  y_last_q;
  logic        colour_q;

  logic [8:0] x0_ext, y0_ext, w_ext, h_ext;
  logic [8:0] w_rem, h_rem, w_eff, h_eff;
  logic [8:0] x_last, y_last;
  logic       wr_req, wr_en;

  // Clip the incoming command against the frame buffer (9-bit, no wrap)
  always_comb begin
    x0_ext = {1'b0, bus.CMD_X0};
    y0_ext = {2'b00, bus.CMD_Y0};
    w_ext  = {1'b0, bus.CMD_W};
    h_ext  = {2'b00, bus.CMD_H};
    w_rem  = '0;
    h_rem  = '0;
    w_eff  = '0;
    h_eff  = '0;
    if (x0_ext < FbW && y0_ext < FbH) begin
      w_rem = FbW - x0_ext;
      h_rem = FbH - y0_ext;
      w_eff = (w_ext < w_rem) ? w_ext : w_rem;
      h_eff = (h_ext < h_rem) ? h_ext : h_rem;
    end
    // Only meaningful when both effective sizes are non-zero
    x_last = x0_ext + w_eff - 9'd1;
    y_last = y0_ext + h_eff - 9'd1;
  end

  // Fill FSM with row/column counters; write states advance only when granted
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
      colour_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.CMD_VALID) begin
            x0_q     <= bus.CMD_X0;
            x_q      <= bus.CMD_X0;
            y_q      <= bus.CMD_Y0;
            x_last_q <= x_last;
            y_last_q <= y_last;
            colour_q <= bus.CMD_COLOUR;
            state_q  <= (w_eff == '0 || h_eff == '0) ? StDone : StWrY;
          end
        end
        StWrY: begin
          if (bus.BUS_GNT) state_q <= StWrX;
        end
        StWrX: begin
          if (bus.BUS_GNT) state_q <= StWrD;
        end
        StWrD: begin
          if (bus.BUS_GNT) begin
            if ({1'b0, x_q} != x_last_q) begin
              x_q     <= x_q + 8'd1;
              state_q <= StWrX;
            end else if ({2'b00, y_q} != y_last_q) begin
              x_q     <= x0_q;
              y_q     <= y_q + 7'd1;
              state_q <= StWrY;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_req = (state_q == StWrY) || (state_q == StWrX) || (state_q == StWrD);
  assign wr_en  = wr_req && bus.BUS_GNT;

  // Status and bus outputs; address/data forced to zero when not writing
  always_comb begin
    bus.CMD_READY = (state_q == StIdle);
    bus.BUSY      = (state_q != StIdle);
    bus.DONE      = (state_q == StDone);
    bus.BUS_REQ   = wr_req;
    bus.BUS_WE    = wr_en;
    bus.BUS_ADDR  = '0;
    bus.BUS_DATA  = '0;
    if (wr_en) begin
      case (state_q)
        StWrY: begin
          bus.BUS_ADDR = BASE_ADDR + REG_Y_OFS;
          bus.BUS_DATA = {1'b0, y_q};
        end
        StWrX: begin
          bus.BUS_ADDR = BASE_ADDR + REG_X_OFS;
          bus.BUS_DATA = x_q;
        end
        StWrD: begin
          bus.BUS_ADDR = BASE_ADDR + REG_DATA_OFS;
          bus.BUS_DATA = {7'b0, colour_q};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill_master.sv
// Directed bench for vga_rect_fill_master with a write scoreboard.
module tb_vga_rect_fill_master;

  logic CLK;
  logic RESET;

  vga_rect_fill_master_if bus_if ();

  vga_rect_fill_master dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {11'd0, bus_if.CMD_READY, bus_if.BUS_REQ, bus_if.BUS_WE,
                           bus_if.BUSY, bus_if.DONE}, 16'b1_0000);
    check({tag, "_addr_data"}, {bus_if.BUS_ADDR, bus_if.BUS_DATA}, 16'h0000);
  endtask

  // Reference model: clip, then queue the expected write sequence
  task automatic push_fill(input int x0, input int y0, input int w, input int h,
                           input bit c);
    int weff, heff;
    if (x0 >= 160 || y0 >= 120) begin
      weff = 0;
      heff = 0;
    end else begin
      weff = (w < 160 - x0) ? w : 160 - x0;
      heff = (h < 120 - y0) ? h : 120 - y0;
    end
    if (weff != 0 && heff != 0) begin
      for (int r = 0; r < heff; r++) begin
        exp_q.push_back({8'hB0, 8'(y0 + r)});
        for (int k = 0; k < weff; k++) begin
          exp_q.push_back({8'hB1, 8'(x0 + k)});
          exp_q.push_back({8'hB2, 7'd0, c});
        end
      end
    end
  endtask

  // Present a command; accepted at the next rising edge, returns just after it
  task automatic send_cmd(input int x0, input int y0, input int w, input int h,
                          input bit c);
    check("ready_before_cmd", {15'd0, bus_if.CMD_READY}, 16'd1);
    bus_if.CMD_X0     = 8'(x0);
    bus_if.CMD_Y0     = 7'(y0);
    bus_if.CMD_W      = 8'(w);
    bus_if.CMD_H      = 7'(h);
    bus_if.CMD_COLOUR = c;
    bus_if.CMD_VALID  = 1'b1;
    @(posedge CLK);
    #1;
    bus_if.CMD_VALID  = 1'b0;
  endtask

  // Count cycles until DONE is observed, bounded
  task automatic wait_done(output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      cyc++;
      if (bus_if.DONE === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {15'd0, seen}, 16'd1);
  endtask

  // Bus monitor: each write must match the head of the scoreboard;
  // address/data must be zero whenever no write is in progress
  always @(negedge CLK) begin
    if (bus_if.BUS_WE === 1'b1) begin
      wr_count++;
      check("write_expected", {15'd0, exp_q.size() != 0}, 16'd1);
      if (exp_q.size() != 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("write", {bus_if.BUS_ADDR, bus_if.BUS_DATA}, e);
      end
    end else begin
      check("idle_bus_zero", {bus_if.BUS_ADDR, bus_if.BUS_DATA}, 16'h0000);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    RESET             = 1'b1;
    bus_if.BUS_GNT    = 1'b0;
    bus_if.CMD_VALID  = 1'b0;
    bus_if.CMD_X0     = '0;
    bus_if.CMD_Y0     = '0;
    bus_if.CMD_W      = '0;
    bus_if.CMD_H      = '0;
    bus_if.CMD_COLOUR = 1'b0;
    #3;
    check_reset_outputs("reset_state");
    @(posedge CLK);
    #1;
    RESET          = 1'b0;
    bus_if.BUS_GNT = 1'b1;

    // Single pixel: three back-to-back writes, DONE the cycle after
    push_fill(5, 3, 1, 1, 1'b1);
    send_cmd(5, 3, 1, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("px1_we", {15'd0, bus_if.BUS_WE}, 16'd1);
    end
    @(negedge CLK);
    check("px1_done", {14'd0, bus_if.DONE, bus_if.BUS_WE}, 16'b10);
    check("px1_busy_in_done", {15'd0, bus_if.BUSY}, 16'd1);
    @(negedge CLK);
    check("px1_ready_back", {14'd0, bus_if.CMD_READY, bus_if.DONE}, 16'b10);
    @(posedge CLK);
    #1;

    // 2x2 fill
    wr_count = 0;
    push_fill(10, 20, 2, 2, 1'b0);
    send_cmd(10, 20, 2, 2, 1'b0);
    wait_done(cyc);
    check("fill2x2_done_cycle", 16'(cyc), 16'd11);
    check("fill2x2_writes", 16'(wr_count), 16'd10);
    @(posedge CLK);
    #1;

    // Clipped to a single corner pixel
    wr_count = 0;
    push_fill(159, 119, 4, 3, 1'b1);
    send_cmd(159, 119, 4, 3, 1'b1);
    wait_done(cyc);
    check("clip_corner_done_cycle", 16'(cyc), 16'd4);
    check("clip_corner_writes", 16'(wr_count), 16'd3);
    @(posedge CLK);
    #1;

    // Fully off-screen
    wr_count = 0;
    push_fill(200, 10, 5, 5, 1'b1);
    send_cmd(200, 10, 5, 5, 1'b1);
    wait_done(cyc);
    check("offscreen_done_cycle", 16'(cyc), 16'd1);
    check("offscreen_writes", 16'(wr_count), 16'd0);
    @(posedge CLK);
    #1;

    // Grant dropped for 4 cycles after the second write
    wr_count = 0;
    push_fill(0, 5, 3, 1, 1'b1);
    send_cmd(0, 5, 3, 1, 1'b1);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    bus_if.BUS_GNT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("gap_we_req", {14'd0, bus_if.BUS_WE, bus_if.BUS_REQ}, 16'b01);
      check("gap_addr_data", {bus_if.BUS_ADDR, bus_if.BUS_DATA}, 16'h0000);
    end
    @(posedge CLK);
    #1;
    bus_if.BUS_GNT = 1'b1;
    wait_done(cyc);
    check("gap_total_writes", 16'(wr_count), 16'd7);
    @(posedge CLK);
    #1;

    // Command held valid while busy must be ignored
    wr_count = 0;
    push_fill(30, 40, 2, 1, 1'b1);
    send_cmd(30, 40, 2, 1, 1'b1);
    bus_if.CMD_X0    = 8'd0;
    bus_if.CMD_Y0    = 7'd0;
    bus_if.CMD_W     = 8'd5;
    bus_if.CMD_H     = 7'd5;
    bus_if.CMD_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check("busy_not_ready", {15'd0, bus_if.CMD_READY}, 16'd0);
      if (bus_if.DONE === 1'b1) break;
    end
    bus_if.CMD_VALID = 1'b0;
    check("busy_done_reached", {15'd0, bus_if.DONE}, 16'd1);
    check("busy_writes", 16'(wr_count), 16'd5);
    @(posedge CLK);
    #1;
    check("busy_ready_after", {15'd0, bus_if.CMD_READY}, 16'd1);

    // Zero width
    wr_count = 0;
    push_fill(3, 3, 0, 2, 1'b1);
    send_cmd(3, 3, 0, 2, 1'b1);
    @(negedge CLK);
    check("zero_w_done", {14'd0, bus_if.DONE, bus_if.BUS_WE}, 16'b10);
    @(posedge CLK);
    #1;
    check("zero_w_writes", 16'(wr_count), 16'd0);

    // Reset during WR_X of a 4x4 fill: only the first Y write happens
    wr_count = 0;
    exp_q.push_back({8'hB0, 8'h00});
    send_cmd(0, 0, 4, 4, 1'b1);
    @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    check_reset_outputs("midfill_reset");
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    repeat (10) @(negedge CLK);
    check("midfill_writes", 16'(wr_count), 16'd1);
    check("midfill_queue_empty", 16'(exp_q.size()), 16'd0);
    @(posedge CLK);
    #1;
    wr_count = 0;
    push_fill(7, 8, 1, 1, 1'b1);
    send_cmd(7, 8, 1, 1, 1'b1);
    wait_done(cyc);
    check("post_reset_done_cycle", 16'(cyc), 16'd4);
    check("post_reset_writes", 16'(wr_count), 16'd3);
    @(posedge CLK);
    #1;

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
